// File: rtl/team_06_clkdiv_pkg.sv
// Shared types and helpers for the team_06 programmable clock divider.
// Optional feature macro used by the slice: TEAM_06_BURST_EN.
package team_06_clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int unsigned DIV_WIDTH_DEFAULT = 16;

  function automatic int unsigned clamp_div(input int unsigned d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/team_06_prog_divider.sv
// Half-period counter and toggle flop with registered rise/fall strobes.
// halt clears the divider and reports a fall strobe if the output was high.
module team_06_prog_divider
  import team_06_clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             init,
  input  logic             halt,
  input  logic [WIDTH-1:0] div_i,
  output logic             toggle_now,
  output logic             div_clk,
  output logic             tick_rise,
  output logic             tick_fall
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             div_clk_q, div_clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Kept as a continuous assign so the controller can use it without a comb loop.
  assign toggle_now = en && (cnt_q == div_i);

  always_comb begin
    cnt_d     = cnt_q;
    div_clk_d = div_clk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (halt) begin
      cnt_d     = '0;
      div_clk_d = 1'b0;
      fall_d    = div_clk_q;
    end else if (init) begin
      cnt_d     = WIDTH'(1);
      div_clk_d = 1'b0;
    end else if (toggle_now) begin
      cnt_d     = WIDTH'(1);
      div_clk_d = ~div_clk_q;
      rise_d    = ~div_clk_q;
      fall_d    = div_clk_q;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_clk_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_clk_q <= div_clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign div_clk   = div_clk_q;
  assign tick_rise = rise_q;
  assign tick_fall = fall_q;

endmodule

// File: rtl/team_06_clkdiv_ctrl.sv
// Clock-divider controller: FSM, divisor handshake, glitch-free divisor swap.
// Define TEAM_06_BURST_EN to add burst_len/burst_done auto-stop after N periods.
module team_06_clkdiv_ctrl
  import team_06_clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH       = DIV_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             div_clk,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [1:0]       state_o
`ifdef TEAM_06_BURST_EN
  ,
  input  logic [7:0]       burst_len,
  output logic             burst_done
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic             xfer, init, halt, en, toggle_now, fall_now, burst_stop;
  logic [WIDTH-1:0] cfg_val;

  assign en        = (state_q != IDLE);
  assign fall_now  = toggle_now && div_clk;
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_val   = WIDTH'(clamp_div(32'(cfg_div)));
  assign cfg_ready = ~pend_flag_q;
  assign busy      = (state_q != IDLE);
  assign state_o   = state_q;

`ifdef TEAM_06_BURST_EN
  logic [7:0] blen_q, blen_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       bdone_q, bdone_d;
  logic       rise_now;

  assign rise_now   = toggle_now && !div_clk;
  assign burst_stop = (state_q == RUN) && (blen_q != '0) && rise_now
                      && ((bcnt_q + 8'd1) == blen_q);
  assign burst_done = bdone_q;

  always_comb begin
    blen_d  = blen_q;
    bcnt_d  = bcnt_q;
    bdone_d = halt;
    if (init) begin
      blen_d = burst_len;
      bcnt_d = '0;
    end else if (rise_now) begin
      bcnt_d = bcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blen_q  <= '0;
      bcnt_q  <= '0;
      bdone_q <= 1'b0;
    end else begin
      blen_q  <= blen_d;
      bcnt_q  <= bcnt_d;
      bdone_q <= bdone_d;
    end
  end
`else
  assign burst_stop = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    init        = 1'b0;
    halt        = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) div_d = cfg_val;
        if (start && !stop) begin
          state_d = RUN;
          init    = 1'b1;
        end
      end
      RUN: begin
        // A stop landing on the falling toggle finishes immediately.
        if (stop && (!div_clk || fall_now)) begin
          halt    = 1'b1;
          state_d = IDLE;
        end else if (stop || burst_stop) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (fall_now) begin
          halt    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        halt    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // A transfer that coincides with entry to IDLE goes straight to div_reg.
    if (state_q != IDLE) begin
      if (xfer) begin
        if (halt) begin
          div_d = cfg_val;
        end else begin
          pend_d      = cfg_val;
          pend_flag_d = 1'b1;
        end
      end else if (pend_flag_q && (fall_now || halt)) begin
        div_d       = pend_q;
        pend_flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= WIDTH'(clamp_div(DEFAULT_DIV));
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
    end
  end

  team_06_prog_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .init      (init),
    .halt      (halt),
    .div_i     (div_q),
    .toggle_now(toggle_now),
    .div_clk   (div_clk),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall)
  );

endmodule

// File: doc/team_06_clkdiv_ctrl.md
Name: team_06_clkdiv_ctrl

Overview:
- Controller and sequencer for a programmable clock divider.
- Owns the divide value and accepts new divisors through a valid/ready handshake.
- Applies a new divisor only at a full-period boundary, so the output never glitches.
- Handles start and graceful stop, and emits one-cycle edge strobes for downstream logic that runs in the clk domain (e.g. display/audio tick consumers).

Parameters:
WIDTH, 16, width of the divisor and the half-period counter
DEFAULT_DIV, 1, divisor loaded at reset (half-period in clk cycles)

Ports:
clk  input  1  system clock; the block's only clock
rst_n  input  1  synchronous, active-low reset
cfg_valid  input  1  new divisor offered
cfg_ready  output  1  controller can accept a divisor
cfg_div  input  WIDTH  requested half-period in clk cycles (0 treated as 1)
start  input  1  begin dividing (honoured only in IDLE)
stop  input  1  request graceful stop
busy  output  1  state != IDLE
div_clk  output  1  divided clock; period = 2*div clk cycles, 50% duty
tick_rise  output  1  high for the single cycle in which div_clk first reads 1
tick_fall  output  1  high for the single cycle in which div_clk first reads 0 after a high phase
state_o  output  2  current state encoding, for debug

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- All state updates on posedge clk. rst_n=0 sampled at an edge forces a reset regardless of state, including mid-period or mid-handshake.
- Reset values: state=IDLE, div_reg=DEFAULT_DIV (clamped to at least 1), pend_flag=0, cnt=0, div_clk=0, tick_rise=0, tick_fall=0, cfg_ready=1, busy=0.
- Handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - A cfg_div of 0 is stored as 1.
- Handshake in IDLE: div_reg takes the new value on the next edge. cfg_ready stays 1.
- Handshake in RUN or STOPPING:
  - The value goes to pend_reg and pend_flag is set.
  - cfg_ready=0 while pend_flag=1.
- States:
  - IDLE: cnt=0, div_clk=0.
    - start=1 && stop=0 -> RUN with cnt=1 and div_clk still 0.
    - The first rise occurs exactly div_reg cycles after the start edge.
  - RUN: each cycle, if cnt==div_reg then cnt<=1 and div_clk<=~div_clk; else cnt<=cnt+1.
    - stop with div_clk=0 -> IDLE next edge. cnt is cleared and no strobe is emitted.
    - stop with div_clk=1 -> STOPPING.
  - STOPPING: counts as in RUN. At the falling toggle, go to IDLE with div_clk=0 and tick_fall=1 that cycle.
- Divisor swap:
  - When pend_flag=1 and a falling toggle (1->0) occurs, div_reg<=pend_reg, pend_flag<=0 and cnt<=1 in the same edge.
  - cfg_ready returns to 1 on the following cycle.
  - On entry to IDLE from STOPPING with pend_flag=1, the pending value is applied on the same edge.
- Simultaneous events:
  - start and stop together: stop wins. IDLE stays IDLE; RUN follows the stop rules.
  - start outside IDLE: ignored.
  - cfg transfer and start in the same IDLE cycle: the new divisor is used for the first period.
- Strobes: tick_rise and tick_fall are registered and asserted on the same edge as the div_clk transition. They are never high together.
- Width rules:
  - The cnt==div_reg compare is unsigned at WIDTH bits.
  - cnt never exceeds div_reg, because a swap restarts cnt at 1.
  - The maximum divisor is 2^WIDTH-1.

Optional Feature:
- TEAM_06_BURST_EN defined:
  - Adds ports burst_len (input, 8 bits) and burst_done (output, 1 bit, 1-cycle pulse).
  - burst_len is captured at start.
  - If the captured burst_len is nonzero, the block auto-enters STOPPING after the burst_len-th tick_rise, so exactly burst_len full periods are produced.
  - burst_done pulses on entry to IDLE, for both burst completion and a manual stop.
  - burst_len=0 means run until stop.
- TEAM_06_BURST_EN undefined: the ports and the burst counter are absent, and the block runs until stop.

Decomposition:
- Package team_06_clkdiv_pkg:
  - state_t enum: IDLE=2'd0, RUN=2'd1, STOPPING=2'd2.
  - Constant DIV_WIDTH_DEFAULT=16.
  - Function clamp_div (0 -> 1).
- Sub-module team_06_prog_divider:
  - Contents: counter and toggle flop, with enable, sync clear, load-at-fall input, and rise/fall strobes.
  - team_06_clkdiv_ctrl holds the FSM, the handshake, pend_reg and the burst logic.

Test Plan:
- Reset with DEFAULT_DIV=3, start pulsed at cycle 0 -> div_clk rises at cycle 3 and falls at cycle 6. tick_rise is high only at cycle 3 and tick_fall only at cycle 6.
- Running at div=4, cfg_div=2 offered mid high phase -> cfg_ready drops the next cycle. The remaining high phase lasts 4 cycles, subsequent half-periods last 2, and cfg_ready rises one cycle after the swap.
- cfg_div=0 in IDLE, then start -> div_clk toggles every cycle (period 2). tick_rise and tick_fall alternate every cycle.
- Stop asserted while div_clk=1 at div=5, 2 cycles into the high phase -> STOPPING. Falls 3 cycles later with tick_fall=1, then IDLE and busy=0. Stop while div_clk=0 -> IDLE next cycle with no strobe.
- start and stop asserted together in IDLE -> stays IDLE, busy=0. rst_n=0 for one edge mid-RUN -> all outputs return to reset values the next cycle and div_reg=DEFAULT_DIV.
- TEAM_06_BURST_EN, burst_len=3, div=2 -> exactly 3 tick_rise pulses. burst_done pulses in the cycle after the 3rd fall, then IDLE.
